// File: rtl/grid_store.sv
// grid_store: 40x30 level grid of 3-bit cells. Port A is read/write, port B is read-only.
//   After reset the grid is filled with the default map (wall border, air interior).
//   A live count of cells holding ENEMY is kept.
// Latency: fill takes GRID_W*GRID_H cycles after reset; reads are 1 cycle; enemy_count
//   reflects an accepted write one cycle after the write edge.
// Backpressure: none. Port A writes issued during the fill are dropped, and ready reports
//   when the grid is usable.
// Ports: clock/resetn; ready; a_x/a_y/a_write/a_in -> a_out; b_x/b_y -> b_out; enemy_count.
module grid_store #(
    parameter int         GRID_W  = 40,
    parameter int         GRID_H  = 30,
    parameter logic [2:0] AIR     = 3'd0,
    parameter logic [2:0] WALL    = 3'd1,
    parameter logic [2:0] ENEMY   = 3'd4,
    parameter int         COUNT_W = 8
) (
    input  logic               clock,
    input  logic               resetn,
    output logic               ready,
    input  logic [5:0]         a_x,
    input  logic [4:0]         a_y,
    input  logic               a_write,
    input  logic [2:0]         a_in,
    output logic [2:0]         a_out,
    input  logic [5:0]         b_x,
    input  logic [4:0]         b_y,
    output logic [2:0]         b_out,
    output logic [COUNT_W-1:0] enemy_count
);

    localparam int           CELLS  = GRID_W * GRID_H;
    localparam logic [10:0]  W11    = 11'(GRID_W);
    localparam logic [6:0]   X_LIM  = 7'(GRID_W);
    localparam logic [5:0]   Y_LIM  = 6'(GRID_H);
    localparam logic [5:0]   X_LAST = 6'(GRID_W - 1);
    localparam logic [4:0]   Y_LAST = 5'(GRID_H - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t state_q, state_d;
    logic [5:0]         fill_x_q, fill_x_d;
    logic [4:0]         fill_y_q, fill_y_d;
    logic [2:0]         a_out_q, a_out_d;
    logic [2:0]         b_out_q, b_out_d;
    logic               pend_inc_q, pend_inc_d;
    logic               pend_dec_q, pend_dec_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [2:0] mem [CELLS];

    logic [10:0] a_addr, b_addr, fill_addr;
    logic        a_in_rng, b_in_rng;
    logic [2:0]  a_cell, b_cell;
    logic        fill_last, fill_border;
    logic        a_accept;
    logic        mem_we;
    logic [10:0] mem_wa;
    logic [2:0]  mem_wd;

    // Addressing: y*GRID_W + x at full 11-bit width, range check on raw coordinates.
    always_comb begin
        a_addr    = {6'b0, a_y} * W11 + {5'b0, a_x};
        b_addr    = {6'b0, b_y} * W11 + {5'b0, b_x};
        fill_addr = {6'b0, fill_y_q} * W11 + {5'b0, fill_x_q};
        a_in_rng  = ({1'b0, a_x} < X_LIM) && ({1'b0, a_y} < Y_LIM);
        b_in_rng  = ({1'b0, b_x} < X_LIM) && ({1'b0, b_y} < Y_LIM);
        // The array is written at the edge, so this read already holds the value written
        // by the previous cycle: back-to-back writes to one cell see the correct old value.
        a_cell    = a_in_rng ? mem[a_addr] : WALL;
        b_cell    = b_in_rng ? mem[b_addr] : WALL;
        fill_last   = (fill_x_q == X_LAST) && (fill_y_q == Y_LAST);
        fill_border = (fill_x_q == 6'd0) || (fill_x_q == X_LAST) ||
                      (fill_y_q == 5'd0) || (fill_y_q == Y_LAST);
        a_accept  = (state_q == S_READY) && a_write && a_in_rng;
    end

    // Single write port: the fill owns it during INIT, port A afterwards.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = AIR;
        if (state_q == S_INIT) begin
            mem_we = 1'b1;
            mem_wa = fill_addr;
            mem_wd = fill_border ? WALL : AIR;
        end else if (a_accept) begin
            mem_we = 1'b1;
            mem_wa = a_addr;
            mem_wd = a_in;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // FSM: state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. READY is only left through reset.
    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && fill_last) begin
            state_d = S_READY;
        end
    end

    // FSM: outputs
    always_comb begin
        ready = (state_q == S_READY);
    end

    // Datapath next-state
    always_comb begin
        fill_x_d   = fill_x_q;
        fill_y_d   = fill_y_q;
        a_out_d    = 3'd0;
        b_out_d    = 3'd0;
        pend_inc_d = 1'b0;
        pend_dec_d = 1'b0;
        count_d    = count_q;

        if (state_q == S_INIT) begin
            if (fill_x_q == X_LAST) begin
                fill_x_d = 6'd0;
                fill_y_d = (fill_y_q == Y_LAST) ? 5'd0 : fill_y_q + 5'd1;
            end else begin
                fill_x_d = fill_x_q + 6'd1;
            end
        end else begin
            a_out_d = a_cell;
            b_out_d = b_cell;
        end

        // Old/new comparison is captured at the write edge, applied one edge later.
        if (a_accept) begin
            pend_inc_d = (a_cell != ENEMY) && (a_in == ENEMY);
            pend_dec_d = (a_cell == ENEMY) && (a_in != ENEMY);
        end

        if (pend_inc_q && count_q != CNT_MAX) begin
            count_d = count_q + COUNT_W'(1);
        end else if (pend_dec_q && count_q != '0) begin
            count_d = count_q - COUNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fill_x_q   <= 6'd0;
            fill_y_q   <= 5'd0;
            a_out_q    <= 3'd0;
            b_out_q    <= 3'd0;
            pend_inc_q <= 1'b0;
            pend_dec_q <= 1'b0;
            count_q    <= '0;
        end else begin
            fill_x_q   <= fill_x_d;
            fill_y_q   <= fill_y_d;
            a_out_q    <= a_out_d;
            b_out_q    <= b_out_d;
            pend_inc_q <= pend_inc_d;
            pend_dec_q <= pend_dec_d;
            count_q    <= count_d;
        end
    end

    assign a_out       = a_out_q;
    assign b_out       = b_out_q;
    assign enemy_count = count_q;

endmodule
